// File: rtl/mult_seq_pkg.sv
// Shared types and constants for the radix-16 Booth multiplier sequencer.
package mult_seq_pkg;

  localparam int DEF_DIGITS          = 8;
  localparam int DEF_SHIFT_PER_DIGIT = 4;
  localparam int DEF_SETTLE_CYCLES   = 2;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INIT,
    ST_LOADB,
    ST_SHIFTB,
    ST_LOADC,
    ST_SHIFTC,
    ST_SETTLE,
    ST_ACC,
    ST_SHIFTA,
    ST_NEXT,
    ST_DONE
  } seq_state_e;

  // The dwell counter exits on zero, so a dwell of len cycles loads len-1.
  function automatic logic [2:0] dwell_load(input int unsigned len);
    return 3'(len - 1);
  endfunction

endpackage

// File: rtl/seq_down_counter.sv
// 3-bit loadable down-counter with zero flag; times every multi-cycle dwell state.
module seq_down_counter (
  input  logic       clk,
  input  logic       srst,
  input  logic       load,
  input  logic [2:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [2:0] count_q;
  logic [2:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != 3'd0)) begin
      count_d = count_q - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      count_q <= 3'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == 3'd0);

endmodule

// File: rtl/mult_sequencer.sv
// Start/Done controller stepping the Booth multiplier datapath one radix-16 digit at a time.
module mult_sequencer
  import mult_seq_pkg::*;
#(
  parameter int DIGITS          = DEF_DIGITS,
  parameter int SHIFT_PER_DIGIT = DEF_SHIFT_PER_DIGIT,
  parameter int SETTLE_CYCLES   = DEF_SETTLE_CYCLES
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       Start,
  input  logic [1:0] Out0,
  input  logic [1:0] Out1,
  output logic [1:0] ModeA,
  output logic [1:0] ModeB,
  output logic [1:0] ModeC,
  output logic       RadixEn,
  output logic       RadixClrN,
  output logic       AccEn,
  output logic       AccClrN,
  output logic       Busy,
  output logic       Done
);

  seq_state_e state_q, state_d;
  logic [2:0] digit_q, digit_d;
  logic [1:0] out1_q, out1_d;

  logic       cnt_load;
  logic [2:0] cnt_val;
  logic       cnt_dec;
  logic       cnt_zero;

  seq_down_counter u_dwell (
    .clk      (CLK),
    .srst     (Reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d   = state_q;
    digit_d   = digit_q;
    out1_d    = out1_q;
    cnt_load  = 1'b0;
    cnt_val   = 3'd0;
    cnt_dec   = 1'b0;
    ModeA     = MODE_HOLD;
    ModeB     = MODE_HOLD;
    ModeC     = MODE_HOLD;
    RadixEn   = 1'b0;
    RadixClrN = 1'b1;
    AccEn     = 1'b0;
    AccClrN   = 1'b1;
    Busy      = (state_q != ST_IDLE);
    Done      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          state_d = ST_INIT;
        end
      end

      ST_INIT: begin
        ModeA     = MODE_LOAD;
        RadixClrN = 1'b0;
        AccClrN   = 1'b0;
        digit_d   = 3'd0;
        state_d   = ST_LOADB;
      end

      // Out0 is captured straight into the dwell counter; Out1 is held for LOADC.
      ST_LOADB: begin
        ModeB  = MODE_LOAD;
        out1_d = Out1;
        if (Out0 != 2'd0) begin
          cnt_load = 1'b1;
          cnt_val  = {1'b0, Out0} - 3'd1;
          state_d  = ST_SHIFTB;
        end else begin
          state_d = ST_LOADC;
        end
      end

      ST_SHIFTB: begin
        ModeB   = MODE_SHL;
        cnt_dec = 1'b1;
        if (cnt_zero) begin
          state_d = ST_LOADC;
        end
      end

      ST_LOADC: begin
        ModeC    = MODE_LOAD;
        cnt_load = 1'b1;
        if (out1_q != 2'd0) begin
          cnt_val = {1'b0, out1_q} - 3'd1;
          state_d = ST_SHIFTC;
        end else begin
          cnt_val = dwell_load(SETTLE_CYCLES);
          state_d = ST_SETTLE;
        end
      end

      ST_SHIFTC: begin
        ModeC   = MODE_SHL;
        cnt_dec = 1'b1;
        if (cnt_zero) begin
          cnt_load = 1'b1;
          cnt_val  = dwell_load(SETTLE_CYCLES);
          state_d  = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        cnt_dec = 1'b1;
        if (cnt_zero) begin
          state_d = ST_ACC;
        end
      end

      ST_ACC: begin
        AccEn = 1'b1;
        if (digit_q == 3'(DIGITS - 1)) begin
          state_d = ST_DONE;
        end else begin
          cnt_load = 1'b1;
          cnt_val  = dwell_load(SHIFT_PER_DIGIT);
          state_d  = ST_SHIFTA;
        end
      end

      ST_SHIFTA: begin
        ModeA   = MODE_SHL;
        cnt_dec = 1'b1;
        if (cnt_zero) begin
          state_d = ST_NEXT;
        end
      end

      ST_NEXT: begin
        RadixEn = 1'b1;
        digit_d = digit_q + 3'd1;
        state_d = ST_LOADB;
      end

      ST_DONE: begin
        Done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      digit_q <= 3'd0;
      out1_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      digit_q <= digit_d;
      out1_q  <= out1_d;
    end
  end

endmodule

// File: tb/tb_mult_sequencer.sv
// Randomized self-checking bench: compares every cycle against a trace built from digit shift counts.
module tb_mult_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] out0;
  logic [1:0] out1;
  logic [1:0] mode_a, mode_b, mode_c;
  logic       radix_en, radix_clr_n, acc_en, acc_clr_n, busy, done;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int lut0 [8];
  int lut1 [8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mult_sequencer dut (
    .CLK       (clk),
    .Reset     (reset),
    .Start     (start),
    .Out0      (out0),
    .Out1      (out1),
    .ModeA     (mode_a),
    .ModeB     (mode_b),
    .ModeC     (mode_c),
    .RadixEn   (radix_en),
    .RadixClrN (radix_clr_n),
    .AccEn     (acc_en),
    .AccClrN   (acc_clr_n),
    .Busy      (busy),
    .Done      (done)
  );

  function automatic logic [11:0] vec(input logic [1:0] ma, input logic [1:0] mb,
                                      input logic [1:0] mc, input logic ren,
                                      input logic rclrn, input logic aen,
                                      input logic aclrn, input logic bsy, input logic dn);
    return {ma, mb, mc, ren, rclrn, aen, aclrn, bsy, dn};
  endfunction

  function automatic logic [11:0] obs();
    return {mode_a, mode_b, mode_c, radix_en, radix_clr_n, acc_en, acc_clr_n, busy, done};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Datapath side: the LUT answers for the current radix digit while B loads, noise otherwise.
  task automatic drive_lut(inout int dig);
    if (mode_b == 2'b11) begin
      out0 = 2'(lut0[dig & 7]);
      out1 = 2'(lut1[dig & 7]);
    end else begin
      out0 = 2'($urandom_range(0, 3));
      out1 = 2'($urandom_range(0, 1));
    end
    if (!radix_clr_n) dig = 0;
    else if (radix_en) dig = dig + 1;
  endtask

  task automatic run_op(input string tag, input bit poke);
    logic [11:0] exp_q[$];
    int sum0 = 0, sum1 = 0;
    int init_cyc = 0, done_cyc = -1;
    int accs = 0, rads = 0, bshl = 0, cshl = 0;
    int dig = 0;
    bit poked = 0;
    logic [11:0] hold_v = vec(2'b00, 2'b00, 2'b00, 0, 1, 0, 1, 1, 0);

    exp_q.push_back(vec(2'b11, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0));
    for (int d = 0; d < 8; d++) begin
      exp_q.push_back(vec(2'b00, 2'b11, 2'b00, 0, 1, 0, 1, 1, 0));
      for (int j = 0; j < lut0[d]; j++) exp_q.push_back(vec(2'b00, 2'b10, 2'b00, 0, 1, 0, 1, 1, 0));
      exp_q.push_back(vec(2'b00, 2'b00, 2'b11, 0, 1, 0, 1, 1, 0));
      for (int j = 0; j < lut1[d]; j++) exp_q.push_back(vec(2'b00, 2'b00, 2'b10, 0, 1, 0, 1, 1, 0));
      for (int j = 0; j < 2; j++) exp_q.push_back(hold_v);
      exp_q.push_back(vec(2'b00, 2'b00, 2'b00, 0, 1, 1, 1, 1, 0));
      if (d < 7) begin
        for (int j = 0; j < 4; j++) exp_q.push_back(vec(2'b10, 2'b00, 2'b00, 0, 1, 0, 1, 1, 0));
        exp_q.push_back(vec(2'b00, 2'b00, 2'b00, 1, 1, 0, 1, 1, 0));
      end
      sum0 += lut0[d];
      sum1 += lut1[d];
    end
    exp_q.push_back(vec(2'b00, 2'b00, 2'b00, 0, 1, 0, 1, 1, 1));
    exp_q.push_back(vec(2'b00, 2'b00, 2'b00, 0, 1, 0, 1, 0, 0));
    exp_q.push_back(vec(2'b00, 2'b00, 2'b00, 0, 1, 0, 1, 0, 0));

    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    init_cyc = cyc;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      check_eq($sformatf("%s_c%0d", tag, i), 32'(obs()), 32'(exp_q[i]));
      if (done && done_cyc < 0) done_cyc = cyc;
      if (acc_en) accs++;
      if (radix_en) rads++;
      if (mode_b == 2'b10) bshl++;
      if (mode_c == 2'b10) cshl++;
      start = 1'b0;
      if (poke && ((mode_a == 2'b10 && !poked) || done)) begin
        start = 1'b1;
        poked = 1'b1;
      end
      drive_lut(dig);
    end
    start = 1'b0;
    check_eq({tag, "_done_lat"}, 32'(done_cyc - init_cyc + 1), 32'(77 + sum0 + sum1));
    check_eq({tag, "_acc_cnt"}, 32'(accs), 32'd8);
    check_eq({tag, "_radix_cnt"}, 32'(rads), 32'd7);
    check_eq({tag, "_bshl_cnt"}, 32'(bshl), 32'(sum0));
    check_eq({tag, "_cshl_cnt"}, 32'(cshl), 32'(sum1));
    $display("op %s: poke=%0d sumOut0=%0d sumOut1=%0d done after %0d cycles",
             tag, poke, sum0, sum1, done_cyc - init_cyc + 1);
  endtask

  task automatic run_abort();
    int dig = 0;
    int guard = 0;
    logic [11:0] idle_v = vec(2'b00, 2'b00, 2'b00, 0, 1, 0, 1, 0, 0);
    for (int d = 0; d < 8; d++) begin
      lut0[d] = (d == 3) ? 2 : 0;
      lut1[d] = 0;
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (!(dig == 3 && mode_b == 2'b10) && guard < 200) begin
      drive_lut(dig);
      @(posedge clk); #1;
      guard++;
    end
    check_eq("abort_reached_shiftb3", 32'(guard < 200), 32'd1);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_eq($sformatf("abort_rst_c%0d", i), 32'(obs()), 32'(idle_v));
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_eq($sformatf("abort_idle_c%0d", i), 32'(obs()), 32'(idle_v));
    end
    $display("op abort: reset during SHIFTB of digit 3, held 3 cycles");
  endtask

  task automatic set_lut_from_b(input logic [31:0] b_low_nibble_pattern0, input int o1);
    for (int d = 0; d < 8; d++) begin
      lut0[d] = 0;
      lut1[d] = 0;
    end
    lut0[0] = int'(b_low_nibble_pattern0);
    lut1[0] = o1;
  endtask

  initial begin
    logic [11:0] idle_v;
    idle_v = vec(2'b00, 2'b00, 2'b00, 0, 1, 0, 1, 0, 0);
    reset = 1'b1;
    start = 1'b0;
    out0  = 2'd0;
    out1  = 2'd0;
    @(posedge clk); #1;
    check_eq("reset_c0", 32'(obs()), 32'(idle_v));
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check_eq("post_reset_idle", 32'(obs()), 32'(idle_v));

    set_lut_from_b(0, 0);
    run_op("b_zero", 1'b0);
    set_lut_from_b(3, 0);
    run_op("b_0x7", 1'b0);
    set_lut_from_b(2, 1);
    run_op("b_0x6", 1'b0);
    set_lut_from_b(0, 0);
    run_op("b_zero_poke", 1'b1);

    run_abort();
    set_lut_from_b(0, 0);
    run_op("fresh_after_abort", 1'b0);

    for (int r = 0; r < 6; r++) begin
      for (int d = 0; d < 8; d++) begin
        lut0[d] = int'($urandom_range(0, 3));
        lut1[d] = int'($urandom_range(0, 1));
      end
      run_op($sformatf("rand%0d", r), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
